// File: rtl/array_stream_serializer.sv
// array_stream_serializer: captures a flag, a tag and a FOO x FOO signed array, then streams the elements one per beat.
// Latency: first beat 1 cycle after capture; 1 beat/cycle with out_ready high; sum pulse 1 cycle after the last accept.
// Backpressure: out_ready low holds the beat fields; in_ready is low while busy; the sum pulse cannot be stalled.
module array_stream_serializer #(
  parameter  int FOO = 4,
  localparam int IW  = ($clog2(FOO) > 1) ? $clog2(FOO) : 1,
  localparam int SW  = FOO + 2*IW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_flag,
  input  logic [31:0]           in_tag,
  input  logic signed [FOO-1:0] in_array [FOO][FOO],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [FOO-1:0] out_data,
  output logic [IW-1:0]         out_row,
  output logic [IW-1:0]         out_col,
  output logic                  out_last,
  output logic [31:0]           out_tag,
  output logic                  sum_valid,
  output logic signed [SW-1:0]  sum
);

  typedef enum logic [1:0] {IDLE, STREAM, SUMMARY} state_t;

  // Index wrap is by compare, so non-power-of-two FOO works.
  localparam logic [IW-1:0] LAST = IW'(FOO - 1);

  state_t                state_q;
  logic signed [FOO-1:0] arr_q [FOO][FOO];
  logic                  flag_q;
  logic [31:0]           tag_q;
  logic [IW-1:0]         row_q, col_q;
  logic [IW-1:0]         row_d, col_d;
  logic signed [SW-1:0]  acc_q, acc_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic signed [FOO-1:0] out_data_q;
  logic                  sum_valid_q;
  logic signed [SW-1:0]  sum_q;
  logic                  accept;

  assign accept = out_valid_q & out_ready;

  // Next element index in the captured scan order (column-major when flag_q is set).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (flag_q) begin
      if (row_q == LAST) begin
        row_d = '0;
        col_d = col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end else begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Running sum including the beat being accepted; the element is sign-extended to SW bits.
  assign acc_d = acc_q + {{(SW-FOO){out_data_q[FOO-1]}}, out_data_q};

  // Control FSM; every output is a register so the beat fields stay put under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flag_q      <= 1'b0;
      tag_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      for (int r = 0; r < FOO; r++) begin
        for (int c = 0; c < FOO; c++) begin
          arr_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            arr_q       <= in_array;
            tag_q       <= in_tag;
            flag_q      <= in_flag;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            // Element (0,0) is taken straight from the port so the first beat is ready next cycle.
            out_data_q  <= in_array[0][0];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            acc_q <= acc_d;
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              sum_q       <= acc_d;
              sum_valid_q <= 1'b1;
              state_q     <= SUMMARY;
            end else begin
              row_q      <= row_d;
              col_q      <= col_d;
              out_data_q <= arr_q[row_d][col_d];
              out_last_q <= (row_d == LAST) && (col_d == LAST);
            end
          end
        end
        SUMMARY: begin
          // Single-cycle pulse; sum reads zero outside it.
          sum_valid_q <= 1'b0;
          sum_q       <= '0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = out_last_q;
  assign out_tag   = tag_q;
  assign sum_valid = sum_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_array_stream_serializer.sv
// Directed bench for array_stream_serializer: a FOO=4 instance for ordering/arithmetic/stall/abort,
// and a FOO=3 instance for back-to-back captures with a non-power-of-two size.
module tb_array_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   vec = 0;
  int   err = 0;

  // FOO = 4 instance
  logic               in_valid4, in_ready4, in_flag4;
  logic [31:0]        in_tag4;
  logic signed [3:0]  arr4 [4][4];
  logic               out_valid4, out_ready4, out_last4;
  logic signed [3:0]  out_data4;
  logic [1:0]         out_row4, out_col4;
  logic [31:0]        out_tag4;
  logic               sum_valid4;
  logic signed [8:0]  sum4;
  int                 ref4 [4][4];

  array_stream_serializer #(.FOO(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_flag(in_flag4), .in_tag(in_tag4), .in_array(arr4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_row(out_row4),
    .out_col(out_col4), .out_last(out_last4), .out_tag(out_tag4),
    .sum_valid(sum_valid4), .sum(sum4)
  );

  // FOO = 3 instance
  logic               in_valid3, in_ready3, in_flag3;
  logic [31:0]        in_tag3;
  logic signed [2:0]  arr3 [3][3];
  logic               out_valid3, out_ready3, out_last3;
  logic signed [2:0]  out_data3;
  logic [1:0]         out_row3, out_col3;
  logic [31:0]        out_tag3;
  logic               sum_valid3;
  logic signed [7:0]  sum3;

  array_stream_serializer #(.FOO(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_flag(in_flag3), .in_tag(in_tag3), .in_array(arr3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_row(out_row3),
    .out_col(out_col3), .out_last(out_last3), .out_tag(out_tag3),
    .sum_valid(sum_valid3), .sum(sum3)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat 0: r*4+c-8, pat 1: all -8, pat 2: all 7
  task automatic load4(input int pat);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ref4[r][c] = (pat == 0) ? (r*4 + c - 8) : (pat == 1) ? -8 : 7;
        arr4[r][c] = 4'(ref4[r][c]);
      end
    end
  endtask

  task automatic capture4(input logic flag, input logic [31:0] tag);
    in_flag4   = flag;
    in_tag4    = tag;
    in_valid4  = 1'b1;
    out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    vec++;
    if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
      err++;
      $display("FAIL capture: out_valid=%b in_ready=%b, want 1 0", out_valid4, in_ready4);
    end
    // Later changes to the input array must not reach the stream.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        arr4[r][c] = ~arr4[r][c];
      end
    end
  endtask

  task automatic stream4(input logic flag, input logic [31:0] tag, input int exp_sum,
                         input bit stall, input int abort_at, input string nm);
    int  k = 0;
    int  r, c;
    bit  done = 0;
    bit  rdy;
    bit  seen;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (sum_valid4) begin
        vec++;
        if (k != 16 || sum4 !== 9'(exp_sum)) begin
          err++;
          $display("FAIL %s sum: got %0d after %0d accepts, want %0d after 16", nm, sum4, k, exp_sum);
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        tick();
        vec++;
        if (sum_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
          err++;
          $display("FAIL %s after_sum: sum_valid=%b in_ready=%b out_valid=%b, want 0 1 0",
                   nm, sum_valid4, in_ready4, out_valid4);
        end
        done = 1;
      end else if (out_valid4) begin
        r = flag ? (k % 4) : (k / 4);
        c = flag ? (k / 4) : (k % 4);
        vec++;
        if (out_data4 !== 4'(ref4[r][c]) || out_row4 !== 2'(r) || out_col4 !== 2'(c) ||
            out_last4 !== (k == 15)) begin
          err++;
          $display("FAIL %s beat%0d: data=%0d row=%0d col=%0d last=%b, want %0d %0d %0d %b",
                   nm, k, out_data4, out_row4, out_col4, out_last4, ref4[r][c], r, c, (k == 15));
        end
        vec++;
        if (out_tag4 !== tag || in_ready4 !== 1'b0) begin
          err++;
          $display("FAIL %s tag%0d: tag=%h in_ready=%b, want %h 0", nm, k, out_tag4, in_ready4, tag);
        end
        rdy = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
        out_ready4 = rdy;
        if (stall) in_valid4 = 1'($urandom_range(0, 1));
        tick();
        if (rdy) k++;
        if (abort_at > 0 && k == abort_at) begin
          rst = 1'b1;
          #1;
          vec++;
          if (out_valid4 !== 1'b0 || out_data4 !== 4'sd0 || out_row4 !== 2'd0 || out_col4 !== 2'd0 ||
              out_last4 !== 1'b0 || out_tag4 !== 32'd0 || sum_valid4 !== 1'b0 || sum4 !== 9'sd0 ||
              in_ready4 !== 1'b1) begin
            err++;
            $display("FAIL %s async_reset: vld=%b data=%0d row=%0d col=%0d last=%b tag=%h sv=%b sum=%0d rdy=%b, want all 0 and rdy 1",
                     nm, out_valid4, out_data4, out_row4, out_col4, out_last4, out_tag4, sum_valid4, sum4, in_ready4);
          end
          out_ready4 = 1'b1;
          tick();
          rst = 1'b0;
          tick();
          vec++;
          if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            err++;
            $display("FAIL %s release: in_ready=%b out_valid=%b, want 1 0", nm, in_ready4, out_valid4);
          end
          seen = 0;
          for (int i = 0; i < 20; i++) begin
            tick();
            if (sum_valid4 || out_valid4) seen = 1;
          end
          vec++;
          if (seen) begin
            err++;
            $display("FAIL %s no_sum_after_abort: saw output activity=1, want 0", nm);
          end
          out_ready4 = 1'b0;
          done = 1;
        end
      end else begin
        vec++;
        err++;
        $display("FAIL %s stream_gap: out_valid=0 after %0d accepts, want 1", nm, k);
        done = 1;
      end
    end
    if (!done) begin
      vec++;
      err++;
      $display("FAIL %s timeout: accepts=%0d, want 16 and a sum pulse", nm, k);
    end
    in_valid4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid4 = 1'b0; in_flag4 = 1'b0; in_tag4 = '0; out_ready4 = 1'b0;
    in_valid3 = 1'b0; in_flag3 = 1'b0; in_tag3 = '0; out_ready3 = 1'b0;
    load4(0);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) arr3[r][c] = '0;
    tick();
    tick();
    vec++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_data4 !== 4'sd0 || out_row4 !== 2'd0 ||
        out_col4 !== 2'd0 || out_last4 !== 1'b0 || out_tag4 !== 32'd0 || sum_valid4 !== 1'b0 || sum4 !== 9'sd0) begin
      err++;
      $display("FAIL reset4: rdy=%b vld=%b data=%0d row=%0d col=%0d last=%b tag=%h sv=%b sum=%0d, want rdy 1 rest 0",
               in_ready4, out_valid4, out_data4, out_row4, out_col4, out_last4, out_tag4, sum_valid4, sum4);
    end
    vec++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || out_data3 !== 3'sd0 || out_tag3 !== 32'd0 ||
        sum_valid3 !== 1'b0 || sum3 !== 8'sd0) begin
      err++;
      $display("FAIL reset3: rdy=%b vld=%b data=%0d tag=%h sv=%b sum=%0d, want rdy 1 rest 0",
               in_ready3, out_valid3, out_data3, out_tag3, sum_valid3, sum3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_row_major();
    load4(0);
    capture4(1'b0, 32'hDEADBEEF);
    stream4(1'b0, 32'hDEADBEEF, -8, 1'b0, 0, "row_major");
  endtask

  task automatic test_col_major();
    load4(0);
    capture4(1'b1, 32'hDEADBEEF);
    stream4(1'b1, 32'hDEADBEEF, -8, 1'b0, 0, "col_major");
  endtask

  task automatic test_extremes();
    load4(1);
    capture4(1'b0, 32'h0000_0001);
    stream4(1'b0, 32'h0000_0001, -128, 1'b0, 0, "all_min");
    load4(2);
    capture4(1'b1, 32'hFFFF_FFFF);
    stream4(1'b1, 32'hFFFF_FFFF, 112, 1'b0, 0, "all_max");
  endtask

  task automatic test_stall();
    load4(0);
    capture4(1'b0, 32'hCAFE_F00D);
    stream4(1'b0, 32'hCAFE_F00D, -8, 1'b1, 0, "stall");
  endtask

  task automatic test_abort();
    load4(0);
    capture4(1'b0, 32'h1234_5678);
    stream4(1'b0, 32'h1234_5678, -8, 1'b0, 5, "abort");
    load4(0);
    capture4(1'b0, 32'h8765_4321);
    stream4(1'b0, 32'h8765_4321, -8, 1'b0, 0, "after_abort");
  endtask

  // FOO=3, elements r-2c (sum -9), in_valid held high across two transactions.
  task automatic test_back_to_back();
    int  k = 0;
    int  r, c;
    int  nt = 0;
    int  ns = 0;
    int  start0 = 0;
    int  start1 = 0;
    bit  prev_vld = 0;
    for (int rr = 0; rr < 3; rr++) for (int cc = 0; cc < 3; cc++) arr3[rr][cc] = 3'(rr - 2*cc);
    in_flag3   = 1'b0;
    in_tag3    = 32'hA5A5_0003;
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    for (int cyc = 0; cyc < 60 && ns < 2; cyc++) begin
      tick();
      if (out_valid3) begin
        if (!prev_vld) begin
          if (nt == 0) start0 = cyc;
          if (nt == 1) start1 = cyc;
          nt++;
          k = 0;
        end
        r = k / 3;
        c = k % 3;
        vec++;
        if (out_data3 !== 3'(r - 2*c) || out_row3 !== 2'(r) || out_col3 !== 2'(c) ||
            out_last3 !== (k == 8) || out_tag3 !== 32'hA5A5_0003) begin
          err++;
          $display("FAIL b2b beat%0d: data=%0d row=%0d col=%0d last=%b tag=%h, want %0d %0d %0d %b a5a50003",
                   k, out_data3, out_row3, out_col3, out_last3, out_tag3, r - 2*c, r, c, (k == 8));
        end
        k++;
      end
      if (sum_valid3) begin
        vec++;
        if (sum3 !== 8'(-9) || k != 9) begin
          err++;
          $display("FAIL b2b sum: got %0d after %0d beats, want -9 after 9", sum3, k);
        end
        ns++;
      end
      prev_vld = out_valid3;
    end
    in_valid3 = 1'b0;
    vec++;
    if (ns != 2 || nt != 2 || (start1 - start0) != 11) begin
      err++;
      $display("FAIL b2b gap: sums=%0d captures=%0d gap=%0d, want 2 2 11", ns, nt, start1 - start0);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_extremes();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
